collatz_range_ctrl: RTL and testbench

//  Sequencer between board I/O and the `range` Collatz engine.
//  - Conditions the raw pushbuttons, latches the base value from the switches and pulses go.
//  - Waits for done, then drives start as the engine's RAM read index so the result window can be browsed.
//  - Registers the displayed n and iteration count for the hex7seg drivers.

---
 rtl/collatz_pkg.sv | 24 ++
 rtl/collatz_range_ctrl_btn_conditioner.sv | 52 +++++
 rtl/collatz_range_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_collatz_range_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/collatz_pkg.sv
// Shared types and default widths for the Collatz range sequencer.
// Contents:
//   state_t        sequencer states
//   DEF_*          default parameter values for collatz_range_ctrl
//   WAIT_BITS      width of the FETCH wait counter
package collatz_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        FETCH  = 3'd3,
        SHOW   = 3'd4
    } state_t;

    localparam int unsigned DEF_RAM_WORDS     = 256;
    localparam int unsigned DEF_RAM_ADDR_BITS = 8;
    localparam int unsigned DEF_N_BITS        = 12;
    localparam int unsigned DEF_COUNT_BITS    = 16;
    localparam int unsigned DEF_TICK_CYCLES   = 4194304;
    localparam int unsigned DEF_READ_LAT      = 1;
    localparam int unsigned WAIT_BITS         = 4;

endpackage

// File: rtl/collatz_range_ctrl_btn_conditioner.sv
// Pushbutton conditioner: 2-FF synchroniser, inversion to active-high,
// sampling on a shared tick strobe and press (rising sample) detection.
// With REPEAT_EN set, a button sampled high on 4 consecutive ticks emits a
// press, then one press per tick while it stays held.
// Ports:
//   clk, reset   system clock, async active-high reset
//   i_tick       one-cycle sample strobe shared by all buttons
//   i_btn_n      raw active-low button
//   o_press      one-cycle press pulse, coincident with i_tick
module btn_conditioner #(
    parameter bit REPEAT_EN = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    input  logic i_btn_n,
    output logic o_press
);

    logic       r_meta;
    logic       r_sync;
    logic       r_prev;
    logic [2:0] r_hold;
    logic       w_edge;
    logic       w_repeat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_hold <= 3'd0;
        end else begin
            r_meta <= ~i_btn_n;
            r_sync <= r_meta;
            if (i_tick) begin
                r_prev <= r_sync;
                // r_hold counts earlier consecutive high samples, saturating at 4
                if (!r_sync)
                    r_hold <= 3'd0;
                else if (r_hold != 3'd4)
                    r_hold <= r_hold + 3'd1;
            end
        end
    end

    assign w_edge   = r_sync & ~r_prev;
    // current sample is the (r_hold+1)-th consecutive high one
    assign w_repeat = REPEAT_EN && r_sync && (r_hold >= 3'd3);
    assign o_press  = i_tick & (w_edge | w_repeat);

endmodule

// File: rtl/collatz_range_ctrl.sv
// Sequencer between board I/O and the range Collatz engine: launches a run
// from the switch base value, then browses the engine's result RAM with the
// inc/dec/home keys and registers the values shown on the 7-segment display.
// Build option: COLLATZ_AUTOREPEAT_EN enables auto-repeat on inc/dec keys.
// Ports:
//   clk, reset            system clock, async active-high reset
//   btn_*_n               raw active-low keys (go, dec, inc, home)
//   sw_base               base n from switches
//   done, count           engine completion pulse and RAM read data
//   go                    one-cycle launch pulse
//   start                 base during launch/run, RAM index while browsing
//   disp_n, disp_count    registered display values
//   busy                  high while launching or running
//
// state  | meaning
// IDLE   | tracking switches, waiting for go
// LAUNCH | one cycle, go pulse, base captured
// RUN    | engine running, waiting for done
// FETCH  | RAM read in flight for current offset
// SHOW   | result displayed, keys browse the window
module collatz_range_ctrl
    import collatz_pkg::*;
#(
    parameter int unsigned RAM_WORDS     = DEF_RAM_WORDS,
    parameter int unsigned RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
    parameter int unsigned N_BITS        = DEF_N_BITS,
    parameter int unsigned COUNT_BITS    = DEF_COUNT_BITS,
    parameter int unsigned TICK_CYCLES   = DEF_TICK_CYCLES,
    parameter int unsigned READ_LAT      = DEF_READ_LAT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_go_n,
    input  logic                  btn_dec_n,
    input  logic                  btn_inc_n,
    input  logic                  btn_home_n,
    input  logic [9:0]            sw_base,
    input  logic                  done,
    input  logic [COUNT_BITS-1:0] count,
    output logic                  go,
    output logic [31:0]           start,
    output logic [N_BITS-1:0]     disp_n,
    output logic [COUNT_BITS-1:0] disp_count,
    output logic                  busy
);

    localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [RAM_ADDR_BITS-1:0] OFF_MAX = RAM_ADDR_BITS'(RAM_WORDS - 1);

`ifdef COLLATZ_AUTOREPEAT_EN
    localparam bit LP_REPEAT = 1'b1;
`else
    localparam bit LP_REPEAT = 1'b0;
`endif

    logic [TICK_W-1:0]        r_tick_cnt;
    logic                     w_tick;
    logic                     w_p_go, w_p_dec, w_p_inc, w_p_home;

    state_t                   r_state, w_state_nxt;
    logic [RAM_ADDR_BITS-1:0] r_offset, w_offset_nxt;
    logic [WAIT_BITS-1:0]     r_wait, w_wait_nxt;
    logic [N_BITS-1:0]        r_base, w_base_nxt;
    logic [31:0]              r_start, w_start_nxt;
    logic [N_BITS-1:0]        r_disp_n, w_disp_n_nxt;
    logic [COUNT_BITS-1:0]    r_disp_count, w_disp_count_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_tick_cnt <= '0;
        else if (w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end

    assign w_tick = (r_tick_cnt == TICK_W'(TICK_CYCLES - 1));

    btn_conditioner #(.REPEAT_EN(1'b0)) u_go (
        .clk(clk), .reset(reset), .i_tick(w_tick), .i_btn_n(btn_go_n), .o_press(w_p_go));
    btn_conditioner #(.REPEAT_EN(1'b0)) u_home (
        .clk(clk), .reset(reset), .i_tick(w_tick), .i_btn_n(btn_home_n), .o_press(w_p_home));
    btn_conditioner #(.REPEAT_EN(LP_REPEAT)) u_inc (
        .clk(clk), .reset(reset), .i_tick(w_tick), .i_btn_n(btn_inc_n), .o_press(w_p_inc));
    btn_conditioner #(.REPEAT_EN(LP_REPEAT)) u_dec (
        .clk(clk), .reset(reset), .i_tick(w_tick), .i_btn_n(btn_dec_n), .o_press(w_p_dec));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_offset     <= '0;
            r_wait       <= '0;
            r_base       <= '0;
            r_start      <= '0;
            r_disp_n     <= '0;
            r_disp_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_offset     <= w_offset_nxt;
            r_wait       <= w_wait_nxt;
            r_base       <= w_base_nxt;
            r_start      <= w_start_nxt;
            r_disp_n     <= w_disp_n_nxt;
            r_disp_count <= w_disp_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_offset_nxt     = r_offset;
        w_wait_nxt       = r_wait;
        w_base_nxt       = r_base;
        w_disp_n_nxt     = r_disp_n;
        w_disp_count_nxt = r_disp_count;
        w_start_nxt      = r_start;

        case (r_state)
            IDLE: begin
                w_disp_n_nxt     = N_BITS'(sw_base);
                w_disp_count_nxt = '0;
                if (w_p_go)
                    w_state_nxt = LAUNCH;
            end
            LAUNCH: begin
                w_base_nxt  = N_BITS'(sw_base);
                w_state_nxt = RUN;
            end
            RUN: begin
                if (done) begin
                    w_offset_nxt = '0;
                    w_wait_nxt   = WAIT_BITS'(READ_LAT);
                    w_state_nxt  = FETCH;
                end
            end
            FETCH: begin
                // start moved on entry; READ_LAT+1 cycles later count is valid
                if (r_wait == '0) begin
                    w_disp_count_nxt = count;
                    w_disp_n_nxt     = r_base + N_BITS'(r_offset);
                    w_state_nxt      = SHOW;
                end else begin
                    w_wait_nxt = r_wait - WAIT_BITS'(1);
                end
            end
            SHOW: begin
                if (w_p_go) begin
                    w_state_nxt = LAUNCH;
                end else if (w_p_home) begin
                    w_offset_nxt = '0;
                    w_wait_nxt   = WAIT_BITS'(READ_LAT);
                    w_state_nxt  = FETCH;
                end else if (w_p_inc && !w_p_dec && r_offset != OFF_MAX) begin
                    w_offset_nxt = r_offset + RAM_ADDR_BITS'(1);
                    w_wait_nxt   = WAIT_BITS'(READ_LAT);
                    w_state_nxt  = FETCH;
                end else if (w_p_dec && !w_p_inc && r_offset != '0) begin
                    w_offset_nxt = r_offset - RAM_ADDR_BITS'(1);
                    w_wait_nxt   = WAIT_BITS'(READ_LAT);
                    w_state_nxt  = FETCH;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // start is chosen by the state being entered so it is already
        // correct in the first cycle of that state
        case (w_state_nxt)
            IDLE, LAUNCH: w_start_nxt = 32'(sw_base);
            RUN:          w_start_nxt = r_start;
            default:      w_start_nxt = 32'(w_offset_nxt);
        endcase
    end

    assign go         = (r_state == LAUNCH);
    assign busy       = (r_state == LAUNCH) || (r_state == RUN);
    assign start      = r_start;
    assign disp_n     = r_disp_n;
    assign disp_count = r_disp_count;

endmodule

// File: tb/tb_collatz_range_ctrl.sv
module tb_collatz_range_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_go_n, btn_dec_n, btn_inc_n, btn_home_n;
    logic [9:0]  sw_base;
    logic        done;
    logic [15:0] count;
    logic        go;
    logic [31:0] start;
    logic [11:0] disp_n;
    logic [15:0] disp_count;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [3:0] B_DEC  = 4'b0001;
    localparam logic [3:0] B_INC  = 4'b0010;
    localparam logic [3:0] B_HOME = 4'b0100;
    localparam logic [3:0] B_GO   = 4'b1000;

    collatz_range_ctrl #(
        .TICK_CYCLES(4),
        .READ_LAT(1)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_go_n(btn_go_n), .btn_dec_n(btn_dec_n),
        .btn_inc_n(btn_inc_n), .btn_home_n(btn_home_n),
        .sw_base(sw_base), .done(done), .count(count),
        .go(go), .start(start), .disp_n(disp_n),
        .disp_count(disp_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // result RAM of the range engine: one cycle read latency, indexed by start
    logic [15:0] ram [256];
    always @(posedge clk) count <= ram[start[7:0]];

    // go pulse monitor
    int          go_pulses = 0;
    int          go_cycles = 0;
    logic [31:0] go_start  = '0;
    logic        go_busy   = 1'b0;
    logic        go_prev   = 1'b0;
    always @(negedge clk) begin
        if (go === 1'b1) begin
            go_cycles++;
            go_start = start;
            go_busy  = busy;
            if (!go_prev) go_pulses++;
        end
        go_prev = (go === 1'b1);
    end

    function automatic int steps(input int n0);
        int n = n0;
        int s = 0;
        while (n > 1) begin
            if (n % 2 == 0) n = n / 2;
            else            n = 3 * n + 1;
            s++;
        end
        return s;
    endfunction

    task automatic fill_ram(input int base);
        for (int i = 0; i < 256; i++) ram[i] = 16'(steps(base + i));
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        @(posedge clk); #1;
        btn_dec_n  = ~m[0];
        btn_inc_n  = ~m[1];
        btn_home_n = ~m[2];
        btn_go_n   = ~m[3];
        repeat (hold) @(posedge clk);
        #1;
        btn_dec_n = 1'b1; btn_inc_n = 1'b1; btn_home_n = 1'b1; btn_go_n = 1'b1;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1 done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
    endtask

    task automatic check_show(input string tag, input int off, input int base);
        chk({tag, "_start"}, start, 32'(off));
        chk({tag, "_disp_n"}, 32'(disp_n), 32'((base + off) % 4096));
        chk({tag, "_disp_count"}, 32'(disp_count), 32'(steps(base + off)));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [3:0] btn;
        int         exp_start;
        int         exp_disp_n;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int m_off;
        int gp;
        int r;
        logic [3:0] mask;

        vecs[0] = '{B_DEC,  0, 27};
        vecs[1] = '{B_INC,  1, 28};
        vecs[2] = '{B_INC,  2, 29};
        vecs[3] = '{B_INC,  3, 30};
        vecs[4] = '{B_HOME, 0, 27};
        vecs[5] = '{B_DEC,  0, 27};

        reset = 1'b1;
        btn_go_n = 1'b1; btn_dec_n = 1'b1; btn_inc_n = 1'b1; btn_home_n = 1'b1;
        sw_base = 10'd27;
        done = 1'b0;
        fill_ram(27);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_go", 32'(go), 0);
        chk("rst_start", start, 0);
        chk("rst_disp_n", 32'(disp_n), 0);
        chk("rst_disp_count", 32'(disp_count), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("idle_start", start, 27);
        chk("idle_disp_n", 32'(disp_n), 27);
        chk("idle_disp_count", 32'(disp_count), 0);

        // launch, held across several ticks
        press(B_GO, 20);
        chk("go_pulses", 32'(go_pulses), 1);
        chk("go_cycles", 32'(go_cycles), 1);
        chk("go_start", go_start, 27);
        chk("go_busy", 32'(go_busy), 1);
        chk("run_busy", 32'(busy), 1);

        // completion and first fetch
        @(posedge clk); #1 done = 1'b1;
        @(posedge clk); #1;
        chk("done_start", start, 0);
        done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("first_disp_n", 32'(disp_n), 27);
        chk("first_disp_count", 32'(disp_count), 111);
        chk("first_busy", 32'(busy), 0);

        foreach (vecs[i]) begin
            press(vecs[i].btn, 10);
            chk($sformatf("vec%0d_start", i), start, 32'(vecs[i].exp_start));
            chk($sformatf("vec%0d_disp_n", i), 32'(disp_n), 32'(vecs[i].exp_disp_n));
            chk($sformatf("vec%0d_disp_count", i), 32'(disp_count), 32'(steps(vecs[i].exp_disp_n)));
        end

        // random browse against the window model
        m_off = 0;
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 3));
            case (r)
                0: begin mask = B_DEC;  if (m_off > 0)   m_off--; end
                1: begin mask = B_HOME; m_off = 0; end
                default: begin mask = B_INC; if (m_off < 255) m_off++; end
            endcase
            press(mask, 10);
            check_show($sformatf("rnd%0d", k), m_off, 27);
        end

        while (m_off < 255) begin
            press(B_INC, 10);
            m_off++;
        end
        check_show("top", 255, 27);
        press(B_INC, 10);
        check_show("inc_at_top", 255, 27);
        press(B_DEC, 10);
        check_show("dec_from_top", 254, 27);
        press(B_INC, 10);
        check_show("back_to_top", 255, 27);

        press(B_HOME, 10);
        for (int k = 0; k < 5; k++) press(B_INC, 10);
        check_show("off5", 5, 27);
        press(B_INC | B_DEC, 10);
        check_show("inc_dec_same", 5, 27);

        // go beats home on the same tick
        gp = go_pulses;
        press(B_GO | B_HOME, 10);
        chk("go_over_home_pulse", 32'(go_pulses), 32'(gp + 1));
        chk("go_over_home_busy", 32'(busy), 1);
        press(B_GO, 10);
        chk("run_go_ignored", 32'(go_pulses), 32'(gp + 1));

        // reset mid-run, late done ignored
        reset = 1'b1;
        #2;
        chk("rr_go", 32'(go), 0);
        chk("rr_start", start, 0);
        chk("rr_disp_n", 32'(disp_n), 0);
        chk("rr_disp_count", 32'(disp_count), 0);
        chk("rr_busy", 32'(busy), 0);
        sw_base = 10'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        gp = go_pulses;
        repeat (3) @(posedge clk);
        pulse_done();
        repeat (6) @(posedge clk);
        #1;
        chk("late_done_busy", 32'(busy), 0);
        chk("late_done_start", start, 0);
        chk("late_done_disp_n", 32'(disp_n), 0);
        chk("late_done_disp_count", 32'(disp_count), 0);
        chk("late_done_go", 32'(go_pulses), 32'(gp));

        // long hold of inc
        sw_base = 10'd27;
        press(B_GO, 10);
        pulse_done();
        repeat (4) @(posedge clk);
        #1;
        check_show("hold_base", 0, 27);
        press(B_INC, 40);
`ifdef COLLATZ_AUTOREPEAT_EN
        chk("hold_repeat", 32'((start > 1) && (start <= 10)), 1);
`else
        check_show("hold_single", 1, 27);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
